// File: rtl/hmmm_cpu.sv
// HMMM 16-bit CPU with 256x16 unified memory: one instruction per clock, program loaded over the shared bus.
// No backpressure: programming cycles (pgrm_addr/pgrm_data) simply pre-empt execution for that cycle.
module hmmm_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        pgrm_addr,
  input  logic        pgrm_data,
  output logic        read,
  output logic        write,
  inout  wire  [15:0] bus,
  output logic        halt
);

  logic [15:0] mem_q  [256];
  logic [15:0] regs_q [16];
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  load_addr_q;
  logic        halted_q, halted_d;

  logic [15:0] instr;
  logic [3:0]  op, x, y, z;
  logic [7:0]  n;
  logic [15:0] rx, ry, rz, sn, ry_m1;
  logic [15:0] div_q, mod_q;
  logic        exec;

  logic        rf_we, rf2_we, mem_we;
  logic [15:0] rf_wd, rf2_wd, mem_wd;
  logic [7:0]  mem_wa;

  assign instr = mem_q[pc_q];
  assign op    = instr[15:12];
  assign x     = instr[11:8];
  assign y     = instr[7:4];
  assign z     = instr[3:0];
  assign n     = instr[7:0];
  assign rx    = regs_q[x];
  assign ry    = regs_q[y];
  assign rz    = regs_q[z];
  assign sn    = {{8{n[7]}}, n};
  assign ry_m1 = ry - 16'd1;

  // SystemVerilog signed / and % already truncate toward zero with the dividend's sign.
  assign div_q = (rz == 16'd0) ? 16'd0 : 16'($signed(ry) / $signed(rz));
  assign mod_q = (rz == 16'd0) ? 16'd0 : 16'($signed(ry) % $signed(rz));

  assign exec  = rst && !pgrm_addr && !pgrm_data && !halted_q;
  assign read  = exec && (op == 4'h0) && (y == 4'h0) && (z == 4'h1);
  assign write = exec && (op == 4'h0) && (y == 4'h0) && (z == 4'h2);
  assign bus   = write ? rx : 16'hzzzz;
  assign halt  = halted_q;

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_wd    = 16'd0;
    rf2_we   = 1'b0;
    rf2_wd   = ry_m1;
    mem_we   = 1'b0;
    mem_wa   = n;
    mem_wd   = rx;
    if (exec) begin
      pc_d = pc_q + 8'd1;
      case (op)
        4'h0: begin
          if (instr == 16'h0000) begin
            halted_d = 1'b1;
            pc_d     = pc_q;
          end else if (y == 4'h0) begin
            case (z)
              4'h1:    begin rf_we = 1'b1; rf_wd = bus; end
              4'h3:    pc_d = rx[7:0];
              default: ;
            endcase
          end
        end
        4'h1: begin rf_we = 1'b1; rf_wd = sn; end
        4'h2: begin rf_we = 1'b1; rf_wd = mem_q[n]; end
        4'h3: mem_we = 1'b1;
        4'h4: begin
          case (z)
            4'h0: begin rf_we = 1'b1; rf_wd = mem_q[ry[7:0]]; end
            4'h1: begin mem_we = 1'b1; mem_wa = ry[7:0]; end
            4'h2: begin
              rf2_we = 1'b1;
              rf2_wd = ry_m1;
              rf_we  = 1'b1;
              rf_wd  = mem_q[ry_m1[7:0]];
            end
            4'h3: begin
              mem_we = 1'b1;
              mem_wa = ry[7:0];
              rf2_we = 1'b1;
              rf2_wd = ry + 16'd1;
            end
            default: ;
          endcase
        end
        4'h5: begin rf_we = 1'b1; rf_wd = rx + sn; end
        4'h6: begin rf_we = 1'b1; rf_wd = ry + rz; end
        4'h7: begin rf_we = 1'b1; rf_wd = ry - rz; end
        4'h8: begin rf_we = 1'b1; rf_wd = ry * rz; end
        4'h9: begin rf_we = 1'b1; rf_wd = div_q; end
        4'hA: begin rf_we = 1'b1; rf_wd = mod_q; end
        4'hB: begin
          pc_d  = n;
          rf_we = (x != 4'h0);
          rf_wd = {8'd0, pc_q + 8'd1};
        end
        4'hC: if (rx == 16'd0) pc_d = n;
        4'hD: if (rx != 16'd0) pc_d = n;
        4'hE: if (!rx[15] && (rx != 16'd0)) pc_d = n;
        4'hF: if (rx[15]) pc_d = n;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= 8'd0;
      load_addr_q <= 8'd0;
      halted_q    <= 1'b0;
    end else begin
      if (pgrm_addr) load_addr_q <= bus[7:0];
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // rX is written after rY so popr with X==Y leaves the loaded value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 16'd0;
    end else begin
      if (rf2_we && (y != 4'h0)) regs_q[y] <= rf2_wd;
      if (rf_we && (x != 4'h0))  regs_q[x] <= rf_wd;
    end
  end

  // Memory keeps its contents through reset; an edge seen while in reset commits nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (pgrm_data)   mem_q[load_addr_q] <= bus;
      else if (mem_we) mem_q[mem_wa]      <= mem_wd;
    end
  end

endmodule

// File: tb/tb_hmmm_cpu.sv
// Bench for hmmm_cpu: table of hand-derived programs, wrap/abort sequences, random programs vs an ISA model.
module tb_hmmm_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pgrm_addr = 1'b0;
  logic        pgrm_data = 1'b0;
  logic        read, write, halt;
  wire  [15:0] bus;
  logic [15:0] drv_dat = 16'd0;
  logic        drv_en = 1'b0;

  assign bus = drv_en ? drv_dat : 16'hzzzz;
  always #5 clk = ~clk;

  hmmm_cpu dut (
    .clk(clk), .rst(rst), .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data),
    .read(read), .write(write), .bus(bus), .halt(halt)
  );

  typedef struct {
    string       name;
    int          len;
    logic [255:0] w;
    logic [15:0] in_v;
    int          n_exp;
    logic [95:0] e;
    int          steps;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mdl_mem [256];
  logic [15:0] code [16];
  logic [15:0] rd_q[$], wr_q[$], mdl_in[$], exp_q[$];
  vec_t        vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Each word takes an address cycle then a data cycle; ends with reset held low.
  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; pgrm_addr = 1'b1; pgrm_data = 1'b0; drv_en = 1'b1;
      drv_dat = 16'((base + i) % 256);
      @(negedge clk);
      pgrm_addr = 1'b0; pgrm_data = 1'b1; drv_dat = code[i];
      mdl_mem[(base + i) % 256] = code[i];
    end
    @(negedge clk);
    pgrm_data = 1'b0; drv_en = 1'b0; rst = 1'b0;
  endtask

  task automatic run_dut(input string tag, output int steps);
    @(negedge clk);
    chk({tag, "/rst_read"},  {31'd0, read},  32'd0);
    chk({tag, "/rst_write"}, {31'd0, write}, 32'd0);
    chk({tag, "/rst_halt"},  {31'd0, halt},  32'd0);
    rst = 1'b1;
    #1;
    steps = 0;
    wr_q.delete();
    while (!halt && steps < 400) begin
      if (read) begin
        drv_en  = 1'b1;
        drv_dat = 16'd0;
        if (rd_q.size() > 0) drv_dat = rd_q.pop_front();
      end
      if (write) wr_q.push_back(bus);
      @(posedge clk);
      #1 drv_en = 1'b0;
      steps++;
      @(negedge clk);
    end
    drv_en = 1'b0;
    chk({tag, "/halted"}, {31'd0, halt}, 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "/halt_sticky"}, {29'd0, halt, read, write}, 32'b100);
  endtask

  // Instruction-level interpreter straight from the ISA rules, on int arithmetic.
  task automatic model_run(output int steps);
    logic [15:0] r [16];
    logic [15:0] ins, res, t;
    logic [7:0]  nn;
    int          pc, npc, x, y, zz, a, b, sn;
    bit          done, wr;
    for (int i = 0; i < 16; i++) r[i] = 16'd0;
    pc = 0; done = 0; steps = 0;
    exp_q.delete();
    while (!done && steps < 400) begin
      ins = mdl_mem[pc];
      x = int'(ins[11:8]); y = int'(ins[7:4]); zz = int'(ins[3:0]); nn = ins[7:0];
      sn = $signed(nn);
      a = $signed(r[y]); b = $signed(r[zz]);
      npc = (pc + 1) % 256;
      res = 16'd0; wr = 0;
      steps++;
      case (ins[15:12])
        4'h0: begin
          if (ins == 16'h0000) done = 1;
          else if (y == 0 && zz == 1) begin
            wr = 1;
            if (mdl_in.size() > 0) res = mdl_in.pop_front();
          end
          else if (y == 0 && zz == 2) exp_q.push_back(r[x]);
          else if (y == 0 && zz == 3) npc = int'(r[x][7:0]);
        end
        4'h1: begin res = 16'(sn); wr = 1; end
        4'h2: begin res = mdl_mem[nn]; wr = 1; end
        4'h3: mdl_mem[nn] = r[x];
        4'h4: begin
          if (zz == 0) begin res = mdl_mem[r[y][7:0]]; wr = 1; end
          else if (zz == 1) mdl_mem[r[y][7:0]] = r[x];
          else if (zz == 2) begin
            t = r[y] - 16'd1;
            if (y != 0) r[y] = t;
            res = mdl_mem[t[7:0]]; wr = 1;
          end else if (zz == 3) begin
            mdl_mem[r[y][7:0]] = r[x];
            if (y != 0) r[y] = r[y] + 16'd1;
          end
        end
        4'h5: begin res = 16'(int'($signed(r[x])) + sn); wr = 1; end
        4'h6: begin res = 16'(a + b); wr = 1; end
        4'h7: begin res = 16'(a - b); wr = 1; end
        4'h8: begin res = 16'(a * b); wr = 1; end
        4'h9: begin res = (b == 0) ? 16'd0 : 16'(a / b); wr = 1; end
        4'hA: begin res = (b == 0) ? 16'd0 : 16'(a % b); wr = 1; end
        4'hB: begin
          npc = int'(nn);
          res = 16'((pc + 1) % 256); wr = (x != 0);
        end
        4'hC: if (r[x] == 16'd0) npc = int'(nn);
        4'hD: if (r[x] != 16'd0) npc = int'(nn);
        4'hE: if ($signed(r[x]) > 0) npc = int'(nn);
        4'hF: if ($signed(r[x]) < 0) npc = int'(nn);
        default: ;
      endcase
      if (wr && x != 0) r[x] = res;
      if (!done) pc = npc;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] x, y, z;
    logic [7:0] n, m;
    x = 4'($urandom_range(0, 7));
    y = 4'($urandom_range(0, 7));
    z = 4'($urandom_range(0, 7));
    n = 8'($urandom_range(0, 255));
    m = 8'(200 + $urandom_range(0, 31));
    case ($urandom_range(0, 10))
      0:  return {4'h1, x, n};
      1:  return {4'h5, x, n};
      2:  return {4'h6, x, y, z};
      3:  return {4'h7, x, y, z};
      4:  return {4'h8, x, y, z};
      5:  return {4'h9, x, y, z};
      6:  return {4'hA, x, y, z};
      7:  return {4'h0, x, 8'h02};
      8:  return {4'h0, x, 8'h01};
      9:  return {4'h3, x, m};
      default: return {4'h2, x, m};
    endcase
  endfunction

  initial begin
    int st, ms;
    logic [15:0] got;

    vt[0] = '{"rw", 3, 256'({16'h0101, 16'h0102, 16'h0000}), 16'd5, 1, 96'(16'h0005), 3};
    vt[1] = '{"setn_addn", 4, 256'({16'h11FD, 16'h510A, 16'h0102, 16'h0000}), 16'd0, 1, 96'(16'h0007), 4};
    vt[2] = '{"arith", 13, 256'({16'h1207, 16'h13FE, 16'h9423, 16'h0402, 16'hA423, 16'h0402,
              16'h8423, 16'h0402, 16'h7423, 16'h0402, 16'h9420, 16'h0402, 16'h0000}), 16'd0, 5,
              96'({16'hFFFD, 16'h0001, 16'hFFF2, 16'h0009, 16'h0000}), 13};
    vt[3] = '{"loop", 5, 256'({16'h1103, 16'h51FF, 16'hD101, 16'h0102, 16'h0000}), 16'd0, 1, 96'(16'h0000), 9};
    vt[4] = '{"calln", 6, 256'({16'h6000, 16'hBE04, 16'h0000, 16'h0000, 16'h0E02, 16'h0000}), 16'd0, 1,
              96'(16'h0002), 4};
    vt[5] = '{"stack", 14, 256'({16'h1155, 16'h31C8, 16'h22C8, 16'h0202, 16'h1F64, 16'h41F3, 16'h132A,
              16'h43F3, 16'h44F2, 16'h45F2, 16'h0402, 16'h0502, 16'h0F02, 16'h0000}), 16'd0, 4,
              96'({16'h0055, 16'h002A, 16'h0055, 16'h0064}), 14};
    vt[6] = '{"branches", 13, 256'({16'h11FF, 16'hF104, 16'h0102, 16'h0000, 16'hE102, 16'hC007, 16'h0000,
              16'h1209, 16'h130B, 16'h0303, 16'h0000, 16'h0202, 16'h0000}), 16'd0, 1, 96'(16'h0009), 9};
    vt[7] = '{"nop_enc", 6, 256'({16'h0105, 16'h4125, 16'h0300, 16'h1004, 16'h0002, 16'h0000}), 16'd0, 1,
              96'(16'h0000), 6};

    #3 rst = 1'b0;

    // Zero the whole memory so the model and the DUT start from the same image.
    for (int i = 0; i < 16; i++) code[i] = 16'd0;
    for (int blk = 0; blk < 16; blk++) load(blk * 16, 16);

    for (int v = 0; v < 8; v++) begin
      if (v > 0) chk({vt[v].name, "/halt_before_prog"}, {31'd0, halt}, 32'd1);
      for (int i = 0; i < vt[v].len; i++) code[i] = vt[v].w[16 * (vt[v].len - 1 - i) +: 16];
      load(0, vt[v].len);
      rd_q.delete(); rd_q.push_back(vt[v].in_v);
      mdl_in.delete(); mdl_in.push_back(vt[v].in_v);
      model_run(ms);
      run_dut(vt[v].name, st);
      chk({vt[v].name, "/steps"}, 32'(st), 32'(vt[v].steps));
      chk({vt[v].name, "/n_writes"}, 32'(wr_q.size()), 32'(vt[v].n_exp));
      for (int j = 0; j < vt[v].n_exp; j++) begin
        got = (j < wr_q.size()) ? wr_q[j] : 16'hxxxx;
        chk($sformatf("%s/write%0d", vt[v].name, j), {16'd0, got},
            {16'd0, vt[v].e[16 * (vt[v].n_exp - 1 - j) +: 16]});
      end
    end

    // pc wraps from 255 back to 0.
    code[0] = 16'hD103; code[1] = 16'hB0FF; code[2] = 16'h0000; code[3] = 16'h0102; code[4] = 16'h0000;
    load(0, 5);
    code[0] = 16'h1109;
    load(255, 1);
    mdl_in.delete(); rd_q.delete();
    model_run(ms);
    run_dut("wrap", st);
    chk("wrap/steps", 32'(st), 32'd6);
    chk("wrap/n_writes", 32'(wr_q.size()), 32'd1);
    chk("wrap/write0", {16'd0, (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx}, 32'h0009);

    // Reset landing just before the edge that would retire storen must discard the store.
    code[0] = 16'h1105; code[1] = 16'h31D2; code[2] = 16'h0000;
    load(0, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4 rst = 1'b0;
    #0;
    chk("abort/read", {30'd0, read, write}, 32'd0);
    @(negedge clk);
    chk("abort/halt", {31'd0, halt}, 32'd0);
    code[0] = 16'h22D2; code[1] = 16'h0202; code[2] = 16'h0000;
    load(0, 3);
    model_run(ms);
    run_dut("abort_chk", st);
    chk("abort_chk/steps", 32'(st), 32'd3);
    chk("abort_chk/n_writes", 32'(wr_q.size()), 32'd1);
    chk("abort_chk/mem210", {16'd0, (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx}, 32'h0000);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 12; i++) code[i] = rand_instr();
      code[12] = 16'h0000;
      load(0, 13);
      rd_q.delete();
      for (int i = 0; i < 12; i++) rd_q.push_back(16'($urandom));
      mdl_in = rd_q;
      model_run(ms);
      run_dut($sformatf("rand%0d", t), st);
      chk($sformatf("rand%0d/steps", t), 32'(st), 32'(ms));
      chk($sformatf("rand%0d/n_writes", t), 32'(wr_q.size()), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) begin
        got = (j < wr_q.size()) ? wr_q[j] : 16'hxxxx;
        chk($sformatf("rand%0d/write%0d", t, j), {16'd0, got}, {16'd0, exp_q[j]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
